// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_arb_pkg;

    typedef enum logic {
        e_idle = 1'b0,
        e_busy = 1'b1
    } arb_state_e;

    // Byte width the UART transmit datapath expects by default.
    localparam int uart_byte_width_c = 8;

    // Bits needed to index n items; never less than 1 so a single-client
    // build still has a legal vector width.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_arb_rr_picker.sv
// Round-robin winner search over a request vector, starting at rr_ptr_i.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the winner is consumed.
//
// Ports:
//   req_i     request vector, one bit per client
//   rr_ptr_i  highest-priority index this round
//   winner_o  first set bit at or above rr_ptr_i, else first set bit below it
//   any_v_o   at least one request bit is set
module uart_arb_rr_picker
    import uart_arb_pkg::*;
#(
    parameter int num_req_p = 3
) (
    input  logic [num_req_p-1:0]              req_i,
    input  logic [idx_width(num_req_p)-1:0]   rr_ptr_i,
    output logic [idx_width(num_req_p)-1:0]   winner_o,
    output logic                              any_v_o
);

    localparam int id_w = idx_width(num_req_p);

    // Two candidate searches: one over indices >= rr_ptr_i (the upper,
    // preferred range) and one over the wrapped range below it. The upper
    // hit wins whenever it exists, which gives the wrap-around order.
    logic            hi_found;
    logic            lo_found;
    logic [id_w-1:0] hi_idx;
    logic [id_w-1:0] lo_idx;

    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int k = 0; k < num_req_p; k++) begin
            if (req_i[k]) begin
                if (id_w'(k) >= rr_ptr_i) begin
                    if (!hi_found) begin
                        hi_found = 1'b1;
                        hi_idx   = id_w'(k);
                    end
                end else if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_idx   = id_w'(k);
                end
            end
        end
    end

    assign winner_o = hi_found ? hi_idx : lo_idx;
    assign any_v_o  = hi_found | lo_found;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART transmitter among byte-stream clients.
// Latency: 1 cycle from request to grant in IDLE; granted bytes pass through combinationally.
// Backpressure: tx_ready_i is routed only to the granted client's ready; all others see 0.
//
// Ports:
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   req_v_i/req_data_i/req_last_i  per-client byte stream (client k data at [k*W +: W])
//   req_ready_o               per-client ready, at most one bit high
//   tx_v_o/tx_data_o/tx_ready_i    byte stream to the UART transmitter (data 0 when not valid)
//   grant_v_o, grant_id_o     a client holds the transmitter / which one
//   timeout_o                 one-cycle pulse on forced release after a stall
//
// Optional feature: define UART_TX_ARB_TIMEOUT_EN to add the stall counter that
// force-releases a grant after timeout_cycles_p cycles without a transfer.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int num_req_p        = 3,
    parameter int data_width_p     = uart_byte_width_c,
    parameter int timeout_cycles_p = 104160
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic [num_req_p-1:0]               req_v_i,
    input  logic [num_req_p*data_width_p-1:0]  req_data_i,
    input  logic [num_req_p-1:0]               req_last_i,
    output logic [num_req_p-1:0]               req_ready_o,
    output logic                               tx_v_o,
    output logic [data_width_p-1:0]            tx_data_o,
    input  logic                               tx_ready_i,
    output logic                               grant_v_o,
    output logic [idx_width(num_req_p)-1:0]    grant_id_o,
    output logic                               timeout_o
);

    localparam int id_w = idx_width(num_req_p);

    arb_state_e      state_q, state_d;
    logic [id_w-1:0] grant_id_q, grant_id_d;
    logic [id_w-1:0] rr_ptr_q, rr_ptr_d;
    logic [id_w-1:0] winner;
    logic [id_w-1:0] rr_next;
    logic            any_v;
    logic            busy;
    logic            sel_v;
    logic            sel_last;
    logic            xfer;
    logic            stall_expired;

    logic [data_width_p-1:0] data_arr [num_req_p];

    for (genvar k = 0; k < num_req_p; k++) begin : g_unpack
        assign data_arr[k] = req_data_i[k*data_width_p +: data_width_p];
    end

    uart_arb_rr_picker #(
        .num_req_p (num_req_p)
    ) u_picker (
        .req_i    (req_v_i),
        .rr_ptr_i (rr_ptr_q),
        .winner_o (winner),
        .any_v_o  (any_v)
    );

    assign busy     = (state_q == e_busy);
    assign sel_v    = req_v_i[grant_id_q];
    assign sel_last = req_last_i[grant_id_q];
    assign xfer     = busy & sel_v & tx_ready_i;

    // Explicit compare instead of a modulo so non-power-of-2 client counts
    // wrap at num_req_p rather than at 2**id_w.
    assign rr_next = (grant_id_q == id_w'(num_req_p - 1)) ? '0 : grant_id_q + 1'b1;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int cnt_w = idx_width(timeout_cycles_p);

    logic [cnt_w-1:0] stall_cnt_q, stall_cnt_d;

    // Counts BUSY cycles since the grant or the last accepted byte; holds
    // zero in IDLE so every new grant starts from a clean count.
    always_comb begin
        stall_cnt_d = stall_cnt_q + 1'b1;
        if (!busy || xfer) begin
            stall_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_expired = busy & ~xfer & (stall_cnt_q == cnt_w'(timeout_cycles_p - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^timeout_cycles_p;
    assign stall_expired      = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        case (state_q)
            e_idle: begin
                if (any_v) begin
                    state_d    = e_busy;
                    grant_id_d = winner;
                end
            end
            e_busy: begin
                // A forced release advances the pointer exactly like a normal
                // end of packet, so a stuck client cannot win again next round.
                if ((xfer && sel_last) || stall_expired) begin
                    state_d  = e_idle;
                    rr_ptr_d = rr_next;
                end
            end
            default: begin
                state_d = e_idle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= e_idle;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    always_comb begin
        req_ready_o = '0;
        for (int k = 0; k < num_req_p; k++) begin
            if (busy && (grant_id_q == id_w'(k))) begin
                req_ready_o[k] = tx_ready_i;
            end
        end
    end

    assign tx_v_o     = busy & sel_v;
    assign tx_data_o  = tx_v_o ? data_arr[grant_id_q] : '0;
    assign grant_v_o  = busy;
    assign grant_id_o = grant_id_q;
    assign timeout_o  = stall_expired;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: 3 clients, 8-bit bytes, 16-cycle stall limit.
// Inputs change 2 time units after the rising edge; outputs are compared 1 unit later.
// Expected values are hand-derived per scenario; the stall scenario follows the build macro.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req_v;
    logic [23:0] req_data;
    logic [2:0]  req_last;
    logic [2:0]  req_ready;
    logic        tx_v;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        grant_v;
    logic [1:0]  grant_id;
    logic        timeout;

    int n_vec  = 0;
    int n_miss = 0;

    uart_tx_arbiter #(
        .num_req_p        (3),
        .data_width_p     (8),
        .timeout_cycles_p (16)
    ) dut (
        .clk_i       (clk),
        .reset_n_i   (rst_n),
        .req_v_i     (req_v),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .tx_v_o      (tx_v),
        .tx_data_o   (tx_data),
        .tx_ready_i  (tx_ready),
        .grant_v_o   (grant_v),
        .grant_id_o  (grant_id),
        .timeout_o   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_cli(input int k, input logic v, input logic [7:0] d, input logic l);
        req_v[k]          = v;
        req_data[k*8 +: 8] = d;
        req_last[k]       = l;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_gv"},  grant_v,   0);
        chk({tag, "_txv"}, tx_v,      0);
        chk({tag, "_txd"}, tx_data,   0);
        chk({tag, "_rdy"}, req_ready, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order [5];
        exp_order = '{0, 1, 2, 0, 1};

        rst_n    = 1'b1;
        req_v    = '0;
        req_data = '0;
        req_last = '0;
        tx_ready = 1'b1;

        // Reset held with all clients requesting: everything quiet.
        #1;
        rst_n    = 1'b0;
        req_v    = 3'b111;
        req_last = 3'b111;
        req_data = {8'h12, 8'h11, 8'h10};
        #1;
        chk_idle("rst");
        chk("rst_gid", grant_id, 0);
        chk("rst_to",  timeout,  0);
        cyc();
        chk_idle("rst_hold");
        rst_n = 1'b1;
        #1;
        cyc();
        #1;
        chk("rel_gid", grant_id, 0);
        chk("rel_gv",  grant_v,  1);
        chk("rel_txd", tx_data,  8'h10);
        chk("rel_rdy", req_ready, 3'b001);
        cyc();
        req_v = '0;
        #1;
        chk_idle("rel_done");

        // Single client 1, one byte (pointer now at 1).
        set_cli(1, 1'b1, 8'hA3, 1'b1);
        #1;
        chk("s1_wait_rdy", req_ready, 3'b000);
        cyc();
        #1;
        chk("s1_gid", grant_id, 1);
        chk("s1_txv", tx_v,     1);
        chk("s1_txd", tx_data,  8'hA3);
        chk("s1_rdy", req_ready, 3'b010);
        cyc();
        set_cli(1, 1'b0, 8'h00, 1'b0);
        #1;
        chk_idle("s1_done");

        // Client 2 one byte, returning the pointer to 0.
        set_cli(2, 1'b1, 8'h5C, 1'b1);
        cyc();
        #1;
        chk("c2_gid", grant_id, 2);
        chk("c2_txd", tx_data,  8'h5C);
        cyc();
        set_cli(2, 1'b0, 8'h00, 1'b0);

        // Packet lock: client 0 sends 11,22,33 while client 2 waits.
        set_cli(0, 1'b1, 8'h11, 1'b0);
        set_cli(2, 1'b1, 8'hC2, 1'b1);
        cyc();
        #1;
        chk("pk_gid0", grant_id, 0);
        chk("pk_b0",   tx_data,  8'h11);
        chk("pk_rdy0", req_ready, 3'b001);
        cyc();
        set_cli(0, 1'b1, 8'h22, 1'b0);
        #1;
        chk("pk_gid1", grant_id, 0);
        chk("pk_b1",   tx_data,  8'h22);
        chk("pk_rdy1", req_ready, 3'b001);
        cyc();
        set_cli(0, 1'b1, 8'h33, 1'b1);
        #1;
        chk("pk_gid2", grant_id, 0);
        chk("pk_b2",   tx_data,  8'h33);
        cyc();
        set_cli(0, 1'b0, 8'h00, 1'b0);
        #1;
        chk("pk_gap_gv",  grant_v, 0);
        chk("pk_gap_txv", tx_v,    0);
        cyc();
        #1;
        chk("pk_next_gid", grant_id, 2);
        chk("pk_next_txd", tx_data,  8'hC2);
        cyc();
        set_cli(2, 1'b0, 8'h00, 1'b0);

        // Round robin with all three clients requesting continuously.
        for (int k = 0; k < 3; k++) begin
            set_cli(k, 1'b1, 8'(8'hA0 + k), 1'b1);
        end
        for (int i = 0; i < 5; i++) begin
            cyc();
            #1;
            chk($sformatf("rr%0d_gid", i), grant_id, exp_order[i]);
            chk($sformatf("rr%0d_txd", i), tx_data,  8'hA0 + exp_order[i]);
            cyc();
            #1;
            chk($sformatf("rr%0d_gap", i), grant_v, 0);
        end
        req_v    = '0;
        req_last = '0;

        // Backpressure: ready low for 50 cycles on the second byte.
        set_cli(0, 1'b1, 8'h31, 1'b0);
        cyc();
        #1;
        chk("bp_gid",  grant_id, 0);
        chk("bp_b0",   tx_data,  8'h31);
        cyc();
        set_cli(0, 1'b1, 8'h32, 1'b1);
        tx_ready = 1'b0;
        #1;
        for (int i = 0; i < 50; i++) begin
            chk("bp_hold_txd", tx_data,   8'h32);
            chk("bp_hold_rdy", req_ready, 3'b000);
            cyc();
        end
        tx_ready = 1'b1;
        #1;
        chk("bp_resume_rdy", req_ready, 3'b001);
        chk("bp_resume_txd", tx_data,   8'h32);
        cyc();
        set_cli(0, 1'b0, 8'h00, 1'b0);
        #1;
        chk_idle("bp_done");

        // Stall: client 1 granted (pointer at 1), sends one byte, then goes quiet.
        set_cli(1, 1'b1, 8'h40, 1'b0);
        cyc();
        #1;
        chk("st_gid",  grant_id, 1);
        chk("st_txd",  tx_data,  8'h40);
        cyc();
        set_cli(1, 1'b0, 8'h00, 1'b0);
        set_cli(2, 1'b1, 8'h77, 1'b1);
        #1;
        chk("st_txd_zero", tx_data, 0);
        chk("st_rdy",      req_ready, 3'b010);
        for (int k = 1; k <= 16; k++) begin
            if (k > 1) begin
                cyc();
                #1;
            end
`ifdef UART_TX_ARB_TIMEOUT_EN
            chk($sformatf("st_to_c%0d", k), timeout, (k == 16) ? 1 : 0);
`else
            chk($sformatf("st_to_c%0d", k), timeout, 0);
`endif
            chk($sformatf("st_gv_c%0d", k), grant_v, 1);
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        cyc();
        #1;
        chk("st_after_gv", grant_v, 0);
        chk("st_after_to", timeout, 0);
        cyc();
        #1;
        chk("st_next_gid", grant_id, 2);
        chk("st_next_txd", tx_data,  8'h77);
`else
        cyc();
        #1;
        chk("st_held_gid", grant_id, 1);
        chk("st_held_gv",  grant_v,  1);
        set_cli(1, 1'b1, 8'h41, 1'b1);
        cyc();
        set_cli(1, 1'b0, 8'h00, 1'b0);
        cyc();
        #1;
        chk("st_next_gid", grant_id, 2);
        chk("st_next_txd", tx_data,  8'h77);
`endif
        cyc();
        set_cli(2, 1'b0, 8'h00, 1'b0);

        // Reset mid-packet with the pointer at 1: afterwards client 0 must win.
        set_cli(0, 1'b1, 8'h50, 1'b1);
        cyc();
        cyc();
        set_cli(0, 1'b0, 8'h00, 1'b0);
        set_cli(1, 1'b1, 8'h61, 1'b0);
        cyc();
        #1;
        chk("mr_gid", grant_id, 1);
        rst_n = 1'b0;
        #1;
        chk_idle("mr_rst");
        chk("mr_rst_gid", grant_id, 0);
        cyc();
        rst_n = 1'b1;
        set_cli(0, 1'b1, 8'h70, 1'b1);
        #1;
        cyc();
        #1;
        chk("mr_after_gid", grant_id, 0);
        chk("mr_after_txd", tx_data,  8'h70);
        cyc();
        req_v    = '0;
        req_last = '0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
